// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits, stop bit,
// one serial sample per ser_en strobe; emits the word with a one-cycle valid pulse.
module serial_frame_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;

    // Insert one received bit at the end that matches the transmit bit order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sh, input logic b);
        logic [WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {sh[WIDTH-2:0], b};
        end else begin
            res = {b, sh[WIDTH-1:1]};
        end
        return res;
    endfunction

    // Frame FSM with registered word, pulses and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            cnt_r      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (ser_en) begin
                case (state_r)
                    IDLE: begin
                        if (!ser_in) begin
                            state_r <= DATA;
                            cnt_r   <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_r <= shift_in(shift_r, ser_in);
                        cnt_r   <= cnt_r + CW'(1);
                        if (cnt_r == LAST_BIT) begin
                            state_r <= STOP;
                        end
                    end
                    STOP: begin
                        // A low stop bit only flags the error; the start search resumes next strobe.
                        if (ser_in) begin
                            data_out   <= shift_r;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Serial-to-parallel frame receiver. It is the receive end of the team's 4-bit loadable parallel-to-serial shift path. It samples one serial bit per enabled clock, detects a start bit, assembles WIDTH data bits and checks the stop bit. It then presents the parallel word with a one-cycle valid pulse, or flags a framing error. It sits between a serial link (or a loopback from the transmit shifter) and parallel consumer logic.

Parameters:
WIDTH, 4, number of data bits per frame (legal range 2..16)
MSB_FIRST, 1, 1 = first data bit received is data_out[WIDTH-1]; 0 = first data bit is data_out[0]

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
ser_en  input  1  bit strobe; ser_in is sampled only on clock edges where ser_en=1
ser_in  input  1  serial line; idle level 1
data_out  output  WIDTH  last correctly framed word; holds its value between frames
data_valid  output  1  one-cycle pulse: data_out updated with a good frame
frame_err  output  1  one-cycle pulse: stop bit sampled as 0, frame discarded
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, active-high): state=IDLE, shift register=0, bit counter=0, data_out=0, data_valid=0, frame_err=0, busy=0. Takes effect immediately, including mid-frame. A partial frame is discarded, and no valid or error pulse is produced for it.
- Frame on the line: start bit (0), then WIDTH data bits, then stop bit (1). Each bit occupies one ser_en-qualified sample.
- FSM states: IDLE, DATA, STOP.
  - IDLE: on ser_en=1 and ser_in=0, go to DATA with the bit counter cleared. Samples of ser_in=1 are ignored and the FSM stays in IDLE.
  - DATA: on each ser_en=1, shift ser_in into the shift register and increment the counter.
    - MSB_FIRST=1: shift left, insert at bit 0.
    - MSB_FIRST=0: shift right, insert at bit WIDTH-1.
    - After the WIDTH-th data sample, go to STOP.
  - STOP: on ser_en=1:
    - ser_in=1: data_out <= shift register; data_valid=1 for exactly that next cycle.
    - ser_in=0: frame_err=1 for one cycle; data_out unchanged.
    - Either way, go to IDLE.
- ser_en=0 in any state: all state, counter, shift register and data_out hold; pulses are low. Arbitrary gaps between strobes are legal.
- Latency: data_valid/frame_err rise on the same clock edge that samples the stop bit, are registered, and are high for one clock only.
- data_valid and frame_err are never high together.
- busy is high from the edge that accepts the start bit through the edge that samples the stop bit (exclusive of the return to IDLE).
- Back-to-back frames: a start bit on the ser_en immediately after the stop-bit sample is accepted. No idle sample is required.
- A stop bit of 0 is not reinterpreted as a start bit. The next start bit is searched for from the following ser_en.
- The bit counter is sized ceil(log2(WIDTH+1)) and never wraps within a frame.

Test Plan:
1. Reset, WIDTH=4, MSB_FIRST=1. Strobe ser_in 0,1,0,1,1,1 (start, data 1011, stop) on consecutive cycles → data_out=4'b1011, data_valid high for 1 cycle after the 6th edge; busy high during edges 1-5; frame_err=0.
2. Same frame but stop bit=0 → frame_err one-cycle pulse, data_out stays 4'b1011 from test 1, data_valid=0, FSM back in IDLE.
3. Frame 0,0,1,1,0,1 with ser_en low for 3 cycles between each strobe → data_out=4'b0110. Outputs hold during gaps; exactly one data_valid pulse.
4. Back-to-back frames 0,1,1,1,1,1 then 0,0,0,0,1,1 with no idle sample between them → two data_valid pulses; data_out=4'b1111 then 4'b0001.
5. Assert rst asynchronously (between clock edges) after the 2nd data bit of a frame → busy=0, data_out=0 immediately; no pulse. A following complete frame 0,1,0,0,1,1 yields 4'b1001.
6. MSB_FIRST=0, frame 0,1,0,1,1,1 → data_out=4'b1101. Idle ser_in=1 with ser_en=1 for 10 cycles beforehand → busy stays 0, no pulses.
